box_raster_engine: RTL and testbench

//  Parametrised successor to the single-mode box drawer. Accepts box requests (x, y, w, h, colour, mode)

---
 rtl/box_raster_engine.sv | 155 +++++++++++++++
 tb/tb_box_raster_engine.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/box_raster_engine.sv
// Box rasteriser: accepts box requests over valid/ready and streams clipped pixels,
// filled or outlined, to the VGA plotter one per cycle with plot_ready back-pressure.
module box_raster_engine #(
  parameter int COORD_W       = 9,
  parameter int VGA_X_W       = 8,
  parameter int VGA_Y_W       = 7,
  parameter int COLOR_W       = 3,
  parameter int SCREEN_WIDTH  = 160,
  parameter int SCREEN_HEIGHT = 120
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [COORD_W-1:0] in_box_x,
  input  logic [COORD_W-1:0] in_box_y,
  input  logic [COORD_W-1:0] in_box_w,
  input  logic [COORD_W-1:0] in_box_h,
  input  logic [COLOR_W-1:0] in_box_color,
  input  logic               in_mode,
  input  logic               plot_ready,
  output logic               plot,
  output logic [VGA_X_W-1:0] vga_x,
  output logic [VGA_Y_W-1:0] vga_y,
  output logic [COLOR_W-1:0] colour,
  output logic               busy,
  output logic               done
);

  localparam int CW = COORD_W + 1;
  localparam logic [COORD_W:0] SCR_W = CW'(SCREEN_WIDTH);
  localparam logic [COORD_W:0] SCR_H = CW'(SCREEN_HEIGHT);
  localparam logic [COORD_W:0] ONE   = CW'(1);
  localparam logic [COORD_W:0] TWO   = CW'(2);

  typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

  state_t           state;
  logic [COORD_W:0] bx, by, x_right, y_bot, xl, yl, cx, cy;
  logic             outline_en;

  logic [COORD_W:0] req_x, req_y, req_w, req_h, req_x_end, req_y_end, req_xl, req_yl;
  logic             req_drop;

  // All request arithmetic is one bit wider than the fields so x+w cannot wrap.
  always_comb begin
    req_x     = {1'b0, in_box_x};
    req_y     = {1'b0, in_box_y};
    req_w     = {1'b0, in_box_w};
    req_h     = {1'b0, in_box_h};
    req_x_end = req_x + req_w;
    req_y_end = req_y + req_h;
    req_xl    = ((req_x_end > SCR_W) ? SCR_W : req_x_end) - ONE;
    req_yl    = ((req_y_end > SCR_H) ? SCR_H : req_y_end) - ONE;
    req_drop  = (req_w == '0) || (req_h == '0) || (req_x >= SCR_W) || (req_y >= SCR_H);
  end

  logic             interior, skip_right, row_end, last_pix;
  logic [COORD_W:0] nx, ny;

  // Next raster position; interior outline rows jump from the left edge straight to the
  // unclipped right edge, or to the next row when that edge is off screen.
  always_comb begin
    interior   = outline_en && (cy != by) && (cy != y_bot);
    skip_right = interior && (cx == bx);
    row_end    = (cx == xl) || (skip_right && (x_right > xl));
    last_pix   = row_end && (cy == yl);
    nx         = cx + ONE;
    ny         = cy;
    if (row_end) begin
      nx = bx;
      ny = cy + ONE;
    end else if (skip_right) begin
      nx = x_right;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      s_ready    <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      plot       <= 1'b0;
      vga_x      <= '0;
      vga_y      <= '0;
      colour     <= '0;
      bx         <= '0;
      by         <= '0;
      x_right    <= '0;
      y_bot      <= '0;
      xl         <= '0;
      yl         <= '0;
      cx         <= '0;
      cy         <= '0;
      outline_en <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (s_valid && s_ready) begin
            s_ready    <= 1'b0;
            busy       <= 1'b1;
            bx         <= req_x;
            by         <= req_y;
            x_right    <= req_x_end - ONE;
            y_bot      <= req_y_end - ONE;
            xl         <= req_xl;
            yl         <= req_yl;
            outline_en <= in_mode && (req_w > TWO) && (req_h > TWO);
            cx         <= req_x;
            cy         <= req_y;
            if (req_drop) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state  <= DRAW;
              plot   <= 1'b1;
              vga_x  <= req_x[VGA_X_W-1:0];
              vga_y  <= req_y[VGA_Y_W-1:0];
              colour <= in_box_color;
            end
          end
        end
        DRAW: begin
          if (plot && plot_ready) begin
            if (last_pix) begin
              plot  <= 1'b0;
              state <= DONE;
              done  <= 1'b1;
            end else begin
              cx    <= nx;
              cy    <= ny;
              vga_x <= nx[VGA_X_W-1:0];
              vga_y <= ny[VGA_Y_W-1:0];
            end
          end
        end
        DONE: begin
          state   <= IDLE;
          done    <= 1'b0;
          busy    <= 1'b0;
          s_ready <= 1'b1;
        end
        default: begin
          state   <= IDLE;
          done    <= 1'b0;
          busy    <= 1'b0;
          plot    <= 1'b0;
          s_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_box_raster_engine.sv
// Self-checking bench for box_raster_engine on a small 6x8 screen; a brute-force
// pixel model fills a scoreboard that a monitor drains as pixels are consumed.
module tb_box_raster_engine;

  localparam int COORD_W = 9;
  localparam int VGA_X_W = 8;
  localparam int VGA_Y_W = 7;
  localparam int COLOR_W = 3;
  localparam int SW      = 6;
  localparam int SH      = 8;

  logic               clock = 1'b0;
  logic               reset_n;
  logic               s_valid;
  logic               s_ready;
  logic [COORD_W-1:0] in_box_x, in_box_y, in_box_w, in_box_h;
  logic [COLOR_W-1:0] in_box_color;
  logic               in_mode;
  logic               plot_ready;
  logic               plot;
  logic [VGA_X_W-1:0] vga_x;
  logic [VGA_Y_W-1:0] vga_y;
  logic [COLOR_W-1:0] colour;
  logic               busy;
  logic               done;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  logic [17:0] exp_q[$];
  logic [17:0] mon_exp;

  box_raster_engine #(
    .COORD_W(COORD_W), .VGA_X_W(VGA_X_W), .VGA_Y_W(VGA_Y_W), .COLOR_W(COLOR_W),
    .SCREEN_WIDTH(SW), .SCREEN_HEIGHT(SH)
  ) dut (
    .clock(clock), .reset_n(reset_n), .s_valid(s_valid), .s_ready(s_ready),
    .in_box_x(in_box_x), .in_box_y(in_box_y), .in_box_w(in_box_w), .in_box_h(in_box_h),
    .in_box_color(in_box_color), .in_mode(in_mode), .plot_ready(plot_ready),
    .plot(plot), .vga_x(vga_x), .vga_y(vga_y), .colour(colour), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  // Every consumed pixel must be the next one the model predicted.
  always @(negedge clock) begin
    if (reset_n && plot && plot_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL pixel: unexpected plot (%0d,%0d) c=%0d, required no pixel", vga_x, vga_y, colour);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({vga_x, vga_y, colour} !== mon_exp) begin
          errors++;
          $display("[TB] FAIL pixel: got (%0d,%0d) c=%0d, required (%0d,%0d) c=%0d",
                   vga_x, vga_y, colour, mon_exp[17:10], mon_exp[9:3], mon_exp[2:0]);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL timeout: simulation exceeded time limit");
    $fatal(1, "[TB] timeout");
  end

  task automatic push_expected(input int x, y, w, h, c, input bit mode, output int npix);
    int xl, yl;
    logic [7:0] px;
    logic [6:0] py;
    logic [2:0] pc;
    npix = 0;
    if (w == 0 || h == 0 || x >= SW || y >= SH) return;
    xl = ((x + w) > SW ? SW : x + w) - 1;
    yl = ((y + h) > SH ? SH : y + h) - 1;
    for (int r = y; r <= yl; r++) begin
      for (int col = x; col <= xl; col++) begin
        if (!mode || w <= 2 || h <= 2 || r == y || r == y + h - 1 || col == x || col == x + w - 1) begin
          px = 8'(col);
          py = 7'(r);
          pc = 3'(c);
          exp_q.push_back({px, py, pc});
          npix++;
        end
      end
    end
  endtask

  task automatic send_box(input int x, y, w, h, c, input bit mode, output int t0, output int npix);
    for (int k = 0; k < 50 && s_ready !== 1'b1; k++) begin
      @(posedge clock);
      #1;
    end
    in_box_x     = 9'(x);
    in_box_y     = 9'(y);
    in_box_w     = 9'(w);
    in_box_h     = 9'(h);
    in_box_color = 3'(c);
    in_mode      = mode;
    s_valid      = 1'b1;
    push_expected(x, y, w, h, c, mode, npix);
    @(posedge clock);
    #1;
    s_valid      = 1'b0;
    t0           = cyc;
    in_box_x     = 9'($urandom_range(0, 511));
    in_box_y     = 9'($urandom_range(0, 511));
    in_box_w     = 9'($urandom_range(0, 511));
    in_box_h     = 9'($urandom_range(0, 511));
    in_box_color = 3'($urandom_range(0, 7));
    in_mode      = 1'($urandom_range(0, 1));
  endtask

  // Latency counts cycles after accept up to and including the done cycle; -1 on timeout.
  task automatic wait_done(input int t0, output int lat);
    lat = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (done === 1'b1) begin
        lat = cyc - t0 + 1;
        return;
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; s_valid = 1'b0; plot_ready = 1'b1; in_mode = 1'b0;
    in_box_x = '0; in_box_y = '0; in_box_w = '0; in_box_h = '0; in_box_color = '0;
    #12;
    checks++;
    if ({s_ready, plot, vga_x, vga_y, colour, busy, done} !== {1'b1, 1'b0, 8'd0, 7'd0, 3'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL reset_state: got s_ready=%b plot=%b x=%0d y=%0d c=%0d busy=%b done=%b, required 1 0 0 0 0 0 0",
               s_ready, plot, vga_x, vga_y, colour, busy, done);
    end
    @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic test_fill();
    int t0, npix, lat;
    send_box(2, 3, 2, 2, 5, 1'b0, t0, npix);
    wait_done(t0, lat);
    checks++;
    if (lat !== 5) begin
      errors++;
      $display("[TB] FAIL fill_latency: got %0d, required 5", lat);
    end
    checks++;
    if ({done, s_ready, busy} !== 3'b101) begin
      errors++;
      $display("[TB] FAIL fill_done_cycle: got done/s_ready/busy=%b, required 101", {done, s_ready, busy});
    end
    @(negedge clock);
    checks++;
    if ({done, s_ready, busy} !== 3'b010) begin
      errors++;
      $display("[TB] FAIL fill_idle_cycle: got done/s_ready/busy=%b, required 010", {done, s_ready, busy});
    end
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("[TB] FAIL fill_leftover: got %0d pixels not plotted, required 0", exp_q.size());
    end
  endtask

  task automatic test_outline();
    int t0, npix, lat;
    send_box(0, 0, 4, 3, 2, 1'b1, t0, npix);
    wait_done(t0, lat);
    checks++;
    if (lat !== 11) begin
      errors++;
      $display("[TB] FAIL outline_latency: got %0d, required 11", lat);
    end
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("[TB] FAIL outline_leftover: got %0d, required 0", exp_q.size());
    end
  endtask

  task automatic test_clip();
    int t0, npix, lat;
    int cases[4][6] = '{'{5, 0, 3, 1, 6, 0}, '{6, 0, 2, 2, 1, 0}, '{3, 6, 5, 5, 7, 1}, '{3, 0, 5, 4, 4, 1}};
    int req_lat[4]  = '{2, 1, 5, 9};
    for (int i = 0; i < 4; i++) begin
      send_box(cases[i][0], cases[i][1], cases[i][2], cases[i][3], cases[i][4], 1'(cases[i][5]), t0, npix);
      wait_done(t0, lat);
      checks++;
      if (lat !== req_lat[i]) begin
        errors++;
        $display("[TB] FAIL clip_latency[%0d]: got %0d, required %0d", i, lat, req_lat[i]);
      end
    end
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("[TB] FAIL clip_leftover: got %0d, required 0", exp_q.size());
    end
  endtask

  task automatic test_stall();
    int t0, npix, lat;
    send_box(0, 2, 3, 1, 3, 1'b0, t0, npix);
    @(posedge clock);
    #1;
    plot_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checks++;
      if ({plot, vga_x, vga_y, colour} !== {1'b1, 8'd1, 7'd2, 3'd3}) begin
        errors++;
        $display("[TB] FAIL stall_hold[%0d]: got plot=%b (%0d,%0d) c=%0d, required 1 (1,2) c=3",
                 i, plot, vga_x, vga_y, colour);
      end
      if (i < 2) begin
        @(posedge clock);
        #1;
      end
    end
    @(posedge clock);
    #1;
    plot_ready = 1'b1;
    wait_done(t0, lat);
    checks++;
    if (lat !== 7) begin
      errors++;
      $display("[TB] FAIL stall_latency: got %0d, required 7", lat);
    end
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("[TB] FAIL stall_leftover: got %0d, required 0", exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    int t0, npix, lat;
    int x, y, w, h;
    bit m;
    for (int i = 0; i < 6; i++) begin
      x = $urandom_range(0, 7);
      y = $urandom_range(0, 9);
      w = $urandom_range(0, 6);
      h = $urandom_range(0, 5);
      m = 1'($urandom_range(0, 1));
      send_box(x, y, w, h, i % 8, m, t0, npix);
      wait_done(t0, lat);
      checks++;
      if (lat !== npix + 1) begin
        errors++;
        $display("[TB] FAIL b2b_latency[%0d] box(%0d,%0d,%0d,%0d,m=%0d): got %0d, required %0d",
                 i, x, y, w, h, m, lat, npix + 1);
      end
    end
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("[TB] FAIL b2b_leftover: got %0d, required 0", exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int t0, npix;
    send_box(0, 0, 6, 8, 6, 1'b0, t0, npix);
    repeat (5) @(negedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({s_ready, plot, vga_x, vga_y, colour, busy, done} !== {1'b1, 1'b0, 8'd0, 7'd0, 3'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL mid_reset: got s_ready=%b plot=%b x=%0d y=%0d c=%0d busy=%b done=%b, required 1 0 0 0 0 0 0",
               s_ready, plot, vga_x, vga_y, colour, busy, done);
    end
    exp_q.delete();
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      checks++;
      if ({plot, s_ready, busy} !== 3'b010) begin
        errors++;
        $display("[TB] FAIL post_reset[%0d]: got plot/s_ready/busy=%b, required 010", i, {plot, s_ready, busy});
      end
    end
  endtask

  task automatic test_drop_stream();
    int acc = 0;
    int dn  = 0;
    int bad = 0;
    @(posedge clock);
    #1;
    in_box_x = 9'd1; in_box_y = 9'd1; in_box_w = 9'd0; in_box_h = 9'd3; in_mode = 1'b0;
    s_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      if (s_ready === 1'b1) acc++;
      if (done === 1'b1) dn++;
      if (plot !== 1'b0 || (busy === 1'b1 && done !== 1'b1)) bad++;
    end
    s_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      if (done === 1'b1) dn++;
      if (plot !== 1'b0 || (busy === 1'b1 && done !== 1'b1)) bad++;
    end
    checks++;
    if (acc !== 6 || dn !== 6) begin
      errors++;
      $display("[TB] FAIL drop_stream_pulses: got accepts=%0d dones=%0d, required 6 and 6", acc, dn);
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("[TB] FAIL drop_stream_plot_busy: got %0d bad cycles, required 0", bad);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_outline();
    test_clip();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    test_drop_stream();
    repeat (3) @(negedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
